// File: rtl/cb_dina_sched_if.sv
// ---------------------------------------------------------------------------
// cb_dina_sched_if
// Bundle between the CB port-A scheduler and the two requesters, the CB
// write-data mapper and CB port A.
//   master : requester side (drives req_*, lk_idx; observes everything else)
//   slave  : scheduler side (cb_dina_sched)
// Signals:
//   req_xyxita / req_lxly  level requests, held until done / err
//   lk_idx                 landmark index, sampled at grant
//   gnt_*                  high for the whole operation
//   done_*                 one-cycle completion pulses
//   err_lm_idx             one-cycle pulse, landmark index out of range
//   busy                   scheduler not idle
//   CB_dina_sel/seq_cnt_out  mapper controls (op code, beat number)
//   CB_wea/CB_addra        CB port-A lane enables and row address
// ---------------------------------------------------------------------------
interface cb_dina_sched_if #(
  parameter int L              = 4,
  parameter int SEQ_CNT_DW     = 5,
  parameter int CB_DINA_SEL_DW = 2,
  parameter int CB_AW          = 10,
  parameter int LM_IDX_DW      = 6
);
  logic                      req_xyxita;
  logic                      req_lxly;
  logic [LM_IDX_DW-1:0]      lk_idx;
  logic                      gnt_xyxita;
  logic                      gnt_lxly;
  logic                      done_xyxita;
  logic                      done_lxly;
  logic                      err_lm_idx;
  logic                      busy;
  logic [CB_DINA_SEL_DW-1:0] CB_dina_sel;
  logic [SEQ_CNT_DW-1:0]     seq_cnt_out;
  logic [L-1:0]              CB_wea;
  logic [CB_AW-1:0]          CB_addra;

  modport master (
    output req_xyxita, req_lxly, lk_idx,
    input  gnt_xyxita, gnt_lxly, done_xyxita, done_lxly, err_lm_idx, busy,
    input  CB_dina_sel, seq_cnt_out, CB_wea, CB_addra
  );

  modport slave (
    input  req_xyxita, req_lxly, lk_idx,
    output gnt_xyxita, gnt_lxly, done_xyxita, done_lxly, err_lm_idx, busy,
    output CB_dina_sel, seq_cnt_out, CB_wea, CB_addra
  );
endinterface

// File: rtl/cb_dina_sched.sv
// ---------------------------------------------------------------------------
// cb_dina_sched
// Arbitrates CB port A between robot-pose writeback (x, y, xita: 3 beats,
// row STATE_ROW) and landmark init (lkx, lky: 2 beats, row LM_BASE_ROW+lk_idx).
// Beat k drives the mapper with seq_cnt_out=k and, one cycle later (matching
// the mapper's registered CB_dina), writes lane k-1 of the selected row.
// Ports:
//   clk        system clock
//   sys_rst_n  asynchronous active-low reset; aborts any operation silently
//   bus        cb_dina_sched_if.slave (requests, grants, mapper and CB controls)
// Sequence per op: IDLE -> SEQ (N beats) -> FLUSH -> IDLE (done pulses).
// All outputs are registered.
// ---------------------------------------------------------------------------
module cb_dina_sched #(
  parameter int L              = 4,
  parameter int SEQ_CNT_DW     = 5,
  parameter int CB_DINA_SEL_DW = 2,
  parameter int CB_AW          = 10,
  parameter int LM_IDX_DW      = 6,
  parameter int NUM_LM         = 32,
  parameter int STATE_ROW      = 0,
  parameter int LM_BASE_ROW    = 1
) (
  input logic             clk,
  input logic             sys_rst_n,
  cb_dina_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEQ, S_FLUSH} state_e;
  typedef enum logic {OP_POSE, OP_LM} op_e;

  localparam logic [CB_DINA_SEL_DW-1:0] SEL_IDLE = '0;
  localparam logic [CB_DINA_SEL_DW-1:0] SEL_POSE = CB_DINA_SEL_DW'(2'b10);
  localparam logic [CB_DINA_SEL_DW-1:0] SEL_LM   = CB_DINA_SEL_DW'(2'b11);
  localparam logic [SEQ_CNT_DW-1:0]     SEQ_ONE  = SEQ_CNT_DW'(1);
  localparam int                        IDX_W    = LM_IDX_DW + 1;

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  op_e                       rr_last_q, rr_last_d;
  logic [SEQ_CNT_DW-1:0]     n_beats_q, n_beats_d;
  logic [CB_AW-1:0]          row_q, row_d;
  logic                      gnt_x_q, gnt_x_d;
  logic                      gnt_l_q, gnt_l_d;
  logic                      done_x_q, done_x_d;
  logic                      done_l_q, done_l_d;
  logic                      err_q, err_d;
  logic                      busy_q, busy_d;
  logic [CB_DINA_SEL_DW-1:0] sel_q, sel_d;
  logic [SEQ_CNT_DW-1:0]     seq_q, seq_d;
  logic [L-1:0]              wea_q, wea_d;
  logic [CB_AW-1:0]          addra_q, addra_d;

  logic req_x, req_l, lm_bad, lm_ok;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    rr_last_d = rr_last_q;
    n_beats_d = n_beats_q;
    row_d     = row_q;
    gnt_x_d   = gnt_x_q;
    gnt_l_d   = gnt_l_q;
    sel_d     = sel_q;
    seq_d     = seq_q;
    done_x_d  = 1'b0;
    done_l_d  = 1'b0;
    err_d     = 1'b0;
    wea_d     = '0;
    addra_d   = addra_q;

    // A requester still sees its own done pulse this cycle and may not have
    // dropped its level request yet; masking it avoids re-granting a
    // finished operation.
    req_x  = bus.req_xyxita & ~done_x_q;
    req_l  = bus.req_lxly   & ~done_l_q;
    lm_bad = {1'b0, bus.lk_idx} >= IDX_W'(NUM_LM);
    lm_ok  = req_l & ~lm_bad;

    // Write side trails the mapper controls by one cycle: beat k seen on
    // seq_q becomes lane k-1 enable on the next cycle.
    if (seq_q != '0) begin
      wea_d   = L'(1) << (seq_q - SEQ_ONE);
      addra_d = row_q;
    end

    unique case (state_q)
      S_IDLE: begin
        err_d = req_l & lm_bad;
        // Pose wins when it is the only valid request or the landmark side
        // was served last.
        if (req_x && (!lm_ok || rr_last_q == OP_LM)) begin
          state_d   = S_SEQ;
          op_d      = OP_POSE;
          n_beats_d = SEQ_CNT_DW'(3);
          row_d     = CB_AW'(STATE_ROW);
          gnt_x_d   = 1'b1;
          sel_d     = SEL_POSE;
          seq_d     = SEQ_ONE;
        end else if (lm_ok) begin
          state_d   = S_SEQ;
          op_d      = OP_LM;
          n_beats_d = SEQ_CNT_DW'(2);
          row_d     = CB_AW'(LM_BASE_ROW) + CB_AW'(bus.lk_idx);
          gnt_l_d   = 1'b1;
          sel_d     = SEL_LM;
          seq_d     = SEQ_ONE;
        end
      end
      S_SEQ: begin
        if (seq_q == n_beats_q) begin
          state_d = S_FLUSH;
          sel_d   = SEL_IDLE;
          seq_d   = '0;
        end else begin
          seq_d = seq_q + SEQ_ONE;
        end
      end
      S_FLUSH: begin
        state_d   = S_IDLE;
        gnt_x_d   = 1'b0;
        gnt_l_d   = 1'b0;
        done_x_d  = (op_q == OP_POSE);
        done_l_d  = (op_q == OP_LM);
        rr_last_d = op_q;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_POSE;
      rr_last_q <= OP_LM;
      n_beats_q <= '0;
      row_q     <= '0;
      gnt_x_q   <= 1'b0;
      gnt_l_q   <= 1'b0;
      done_x_q  <= 1'b0;
      done_l_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      sel_q     <= SEL_IDLE;
      seq_q     <= '0;
      wea_q     <= '0;
      addra_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rr_last_q <= rr_last_d;
      n_beats_q <= n_beats_d;
      row_q     <= row_d;
      gnt_x_q   <= gnt_x_d;
      gnt_l_q   <= gnt_l_d;
      done_x_q  <= done_x_d;
      done_l_q  <= done_l_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      sel_q     <= sel_d;
      seq_q     <= seq_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
    end
  end

  assign bus.gnt_xyxita  = gnt_x_q;
  assign bus.gnt_lxly    = gnt_l_q;
  assign bus.done_xyxita = done_x_q;
  assign bus.done_lxly   = done_l_q;
  assign bus.err_lm_idx  = err_q;
  assign bus.busy        = busy_q;
  assign bus.CB_dina_sel = sel_q;
  assign bus.seq_cnt_out = seq_q;
  assign bus.CB_wea      = wea_q;
  assign bus.CB_addra    = addra_q;

endmodule

// File: tb/tb_cb_dina_sched.sv
// ---------------------------------------------------------------------------
// tb_cb_dina_sched
// Timeline scoreboard: whenever the reference model grants an operation it
// writes the whole expected future waveform (grant, beats, lane writes, done)
// into per-cycle arrays; every simulated cycle the DUT outputs are compared
// against the array entry for that cycle. A small mapper + BRAM model checks
// that the write enables line up with registered mapper data.
// ---------------------------------------------------------------------------
module tb_cb_dina_sched;

  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cb_dina_sched_if #(.L(4), .SEQ_CNT_DW(5), .CB_DINA_SEL_DW(2), .CB_AW(10), .LM_IDX_DW(6)) bus ();

  cb_dina_sched #(
    .L(4), .SEQ_CNT_DW(5), .CB_DINA_SEL_DW(2), .CB_AW(10), .LM_IDX_DW(6),
    .NUM_LM(32), .STATE_ROW(0), .LM_BASE_ROW(1)
  ) dut (
    .clk       (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  // ---------------- mapper + BRAM row 0 model ----------------
  logic [7:0]  pose_val [3];
  logic [31:0] map_dina;
  logic [7:0]  row0 [4];
  logic [3:0]  row0_wr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_dina <= '0;
      row0_wr  <= '0;
      for (int i = 0; i < 4; i++) row0[i] <= 8'h00;
    end else begin
      map_dina <= '0;
      if (bus.CB_dina_sel == 2'b10 && bus.seq_cnt_out >= 5'd1 && bus.seq_cnt_out <= 5'd3)
        map_dina[(int'(bus.seq_cnt_out) - 1) * 8 +: 8] <= pose_val[int'(bus.seq_cnt_out) - 1];
      if (bus.CB_addra == 10'd0)
        for (int i = 0; i < 4; i++)
          if (bus.CB_wea[i]) begin
            row0[i]    <= map_dina[i*8 +: 8];
            row0_wr[i] <= 1'b1;
          end
    end
  end

  // ---------------- expected timeline ----------------
  bit        e_gnt_x  [MAXC];
  bit        e_gnt_l  [MAXC];
  bit        e_done_x [MAXC];
  bit        e_done_l [MAXC];
  bit        e_err    [MAXC];
  bit        e_busy   [MAXC];
  bit [1:0]  e_sel    [MAXC];
  bit [4:0]  e_seq    [MAXC];
  bit [3:0]  e_wea    [MAXC];
  bit        e_aset   [MAXC];
  bit [9:0]  e_aval   [MAXC];

  int       cur;
  int       m_idle_from;
  bit       m_rr_lm;     // last served requester was the landmark side
  bit [9:0] m_addr;
  int       total;
  int       bad;

  task automatic model_clear();
    for (int c = cur; c < cur + 16; c++) begin
      e_gnt_x[c] = 0; e_gnt_l[c] = 0; e_done_x[c] = 0; e_done_l[c] = 0;
      e_err[c] = 0; e_busy[c] = 0; e_sel[c] = '0; e_seq[c] = '0;
      e_wea[c] = '0; e_aset[c] = 0; e_aval[c] = '0;
    end
    m_idle_from = cur;
    m_rr_lm     = 1'b1;
    m_addr      = '0;
  endtask

  // Decision made from the inputs of cycle 'cur'; schedules cycles cur+1...
  task automatic model_edge();
    bit rx, rl, lv, pick_lm;
    int n;
    bit [9:0] row;
    if (rst_n !== 1'b1) return;
    if (cur < m_idle_from) return;
    rx = (bus.req_xyxita === 1'b1) && !e_done_x[cur];
    rl = (bus.req_lxly === 1'b1) && !e_done_l[cur];
    lv = rl && (int'(bus.lk_idx) < 32);
    if (rl && !lv) e_err[cur+1] = 1;
    if (rx && lv)  pick_lm = !m_rr_lm;
    else if (rx)   pick_lm = 1'b0;
    else if (lv)   pick_lm = 1'b1;
    else           return;
    n   = pick_lm ? 2 : 3;
    row = pick_lm ? 10'(1 + int'(bus.lk_idx)) : 10'd0;
    for (int k = 1; k <= n; k++) begin
      e_sel[cur+k]    = pick_lm ? 2'b11 : 2'b10;
      e_seq[cur+k]    = 5'(k);
      e_wea[cur+k+1]  = 4'(1 << (k - 1));
      e_aset[cur+k+1] = 1;
      e_aval[cur+k+1] = row;
    end
    for (int k = 1; k <= n + 1; k++) begin
      if (pick_lm) e_gnt_l[cur+k] = 1; else e_gnt_x[cur+k] = 1;
      e_busy[cur+k] = 1;
    end
    if (pick_lm) e_done_l[cur+n+2] = 1; else e_done_x[cur+n+2] = 1;
    m_idle_from = cur + n + 2;
    m_rr_lm     = pick_lm;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    cur++;
    if (e_aset[cur]) m_addr = e_aval[cur];
    if (rst_n !== 1'b1) m_addr = '0;
    @(negedge clk);
  endtask

  function automatic bit [26:0] exp_vec(int c);
    return {e_gnt_x[c], e_gnt_l[c], e_done_x[c], e_done_l[c], e_err[c], e_busy[c],
            e_sel[c], e_seq[c], e_wea[c], m_addr};
  endfunction

  function automatic logic [26:0] act_vec();
    return {bus.gnt_xyxita, bus.gnt_lxly, bus.done_xyxita, bus.done_lxly, bus.err_lm_idx,
            bus.busy, bus.CB_dina_sel, bus.seq_cnt_out, bus.CB_wea, bus.CB_addra};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    step(); step();
    total++;
    if (act_vec() !== 27'd0) begin
      bad++; $display("FAIL reset_state got=%h want=%h", act_vec(), 27'd0);
    end
    rst_n = 1'b1;
    bus.req_xyxita = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL reset_pre_abort cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
    end
    // now in pose beat 2: abort asynchronously
    rst_n = 1'b0;
    #1;
    total++;
    if (act_vec() !== 27'd0) begin
      bad++; $display("FAIL reset_mid_op got=%h want=%h", act_vec(), 27'd0);
    end
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL reset_hold cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL reset_fresh_op cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
      if (e_done_x[cur]) bus.req_xyxita = 1'b0;
    end
  endtask

  task automatic test_pose();
    bus.req_xyxita = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL pose cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
      if (e_done_x[cur]) bus.req_xyxita = 1'b0;
    end
  endtask

  task automatic test_landmark();
    bus.lk_idx   = 6'd5;
    bus.req_lxly = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL landmark cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
      // after the grant: change index and drop the request; both must be ignored
      if (i == 0) begin
        bus.lk_idx   = 6'd9;
        bus.req_lxly = 1'b0;
      end
    end
  endtask

  task automatic test_bad_index();
    bit saw_gnt;
    bit [5:0] idx_tab [2];
    idx_tab[0] = 6'd32;
    idx_tab[1] = 6'd63;
    saw_gnt = 1'b0;
    for (int t = 0; t < 2; t++) begin
      bus.lk_idx   = idx_tab[t];
      bus.req_lxly = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step(); total++;
        if (act_vec() !== exp_vec(cur)) begin
          bad++; $display("FAIL bad_index idx=%0d cyc=%0d got=%h want=%h", idx_tab[t], cur, act_vec(), exp_vec(cur));
        end
        if (bus.gnt_lxly !== 1'b0) saw_gnt = 1'b1;
        if (e_err[cur]) bus.req_lxly = 1'b0;
      end
    end
    total++;
    if (saw_gnt !== 1'b0) begin
      bad++; $display("FAIL bad_index_gnt got=%0b want=0", saw_gnt);
    end
  endtask

  task automatic test_contention();
    int order [$];
    int overlap;
    logic pgx, pgl;
    overlap = 0;
    rst_n = 1'b0;
    model_clear();
    bus.lk_idx     = 6'd3;
    bus.req_xyxita = 1'b1;
    bus.req_lxly   = 1'b1;
    step(); step();
    rst_n = 1'b1;
    pgx = 1'b0; pgl = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL contention cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
      if (bus.gnt_xyxita === 1'b1 && pgx !== 1'b1) order.push_back(0);
      if (bus.gnt_lxly === 1'b1 && pgl !== 1'b1) order.push_back(1);
      if (bus.gnt_xyxita === 1'b1 && bus.gnt_lxly === 1'b1) overlap++;
      pgx = bus.gnt_xyxita; pgl = bus.gnt_lxly;
    end
    bus.req_xyxita = 1'b0;
    bus.req_lxly   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL contention_drain cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
    end
    total++;
    if (order.size() < 4) begin
      bad++; $display("FAIL contention_grants got=%0d want>=4", order.size());
    end else begin
      for (int k = 0; k < 4; k++)
        if (order[k] !== (k % 2)) begin
          bad++; $display("FAIL contention_order idx=%0d got=%0d want=%0d", k, order[k], k % 2);
          break;
        end
    end
    total++;
    if (overlap !== 0) begin
      bad++; $display("FAIL contention_overlap got=%0d want=0", overlap);
    end
  endtask

  task automatic test_mapper();
    logic [7:0] want [3];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
    for (int k = 0; k < 3; k++) pose_val[k] = want[k];
    rst_n = 1'b0;
    model_clear();
    step();
    rst_n = 1'b1;
    bus.req_xyxita = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL mapper_ctrl cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
      if (e_done_x[cur]) bus.req_xyxita = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (row0_wr[k] !== 1'b1 || row0[k] !== want[k]) begin
        bad++; $display("FAIL mapper_lane%0d got=%h wr=%b want=%h", k, row0[k], row0_wr[k], want[k]);
      end
    end
    total++;
    if (row0_wr[3] !== 1'b0) begin
      bad++; $display("FAIL mapper_lane3 written=%b want=0", row0_wr[3]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
      if (e_done_x[cur]) bus.req_xyxita = 1'b0;
      else if (bus.req_xyxita == 1'b0 && $urandom_range(0, 3) == 0) bus.req_xyxita = 1'b1;
      if (e_done_l[cur] || e_err[cur]) bus.req_lxly = 1'b0;
      else if (bus.req_lxly == 1'b0) begin
        bus.lk_idx = 6'($urandom_range(0, 40));
        if ($urandom_range(0, 2) == 0) bus.req_lxly = 1'b1;
      end else if (e_gnt_l[cur]) begin
        bus.lk_idx = 6'($urandom_range(0, 63));
      end
    end
    bus.req_xyxita = 1'b0;
    bus.req_lxly   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); total++;
      if (act_vec() !== exp_vec(cur)) begin
        bad++; $display("FAIL random_drain cyc=%0d got=%h want=%h", cur, act_vec(), exp_vec(cur));
      end
    end
  endtask

  initial begin
    cur = 0; total = 0; bad = 0;
    m_idle_from = 0; m_rr_lm = 1'b1; m_addr = '0;
    rst_n = 1'b0;
    bus.req_xyxita = 1'b0;
    bus.req_lxly   = 1'b0;
    bus.lk_idx     = '0;
    for (int k = 0; k < 3; k++) pose_val[k] = 8'h00;
    @(negedge clk);
    test_reset();
    test_pose();
    test_landmark();
    test_bad_index();
    test_contention();
    test_mapper();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
